// File: rtl/mac_dot_sequencer_pkg.sv
// Shared types and constants for the FP32 dot-product issue sequencer.
package mac_seq_pkg;

  localparam int DATA_W_DEF = 32;
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    HOLD
  } state_e;

endpackage

// File: rtl/mac_dot_sequencer_operand_fifo.sv
// Synchronous operand-pair FIFO. The read port is combinational from the head entry,
// but a freshly pushed pair only becomes visible through count on the following cycle.
module mac_operand_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/mac_dot_sequencer.sv
// Issue-side sequencer: buffers operand pairs, streams a commanded number of them to the
// MAC, waits out the result latency and hands the captured dot product to the consumer.
module mac_dot_sequencer
  import mac_seq_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH   = 16,
  parameter int RES_LAT = 12,
  localparam int CNT_W  = $clog2(DEPTH + 1),
  localparam int LAT_W  = (RES_LAT > 1) ? $clog2(RES_LAT) : 1
) (
  input  logic              clock_i,
  input  logic              resetn_i,
  input  logic              ld_valid_i,
  output logic              ld_ready_o,
  input  logic [DATA_W-1:0] ld_a_i,
  input  logic [DATA_W-1:0] ld_b_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [CNT_W-1:0]  cmd_len_i,
  output logic              mac_ivalid_o,
  output logic              mac_control_o,
  output logic [DATA_W-1:0] mac_dataA_o,
  output logic [DATA_W-1:0] mac_dataB_o,
  input  logic [DATA_W-1:0] mac_dataout_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [DATA_W-1:0] res_data_o
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic                first_q, first_d;
  logic                mac_ivalid_q, mac_ivalid_d;
  logic                mac_control_q, mac_control_d;
  logic [DATA_W-1:0]   mac_a_q, mac_a_d, mac_b_q, mac_b_d;
  logic                res_valid_q, res_valid_d;
  logic [DATA_W-1:0]   res_data_q, res_data_d;

  logic                fifo_pop, fifo_full, fifo_empty;
  logic [2*DATA_W-1:0] fifo_rdata;

  mac_operand_fifo #(
    .WIDTH (2 * DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clock_i),
    .rst_ni  (resetn_i),
    .push_i  (ld_valid_i),
    .wdata_i ({ld_a_i, ld_b_i}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign ld_ready_o    = !fifo_full;
  assign cmd_ready_o   = (state_q == IDLE);
  assign mac_ivalid_o  = mac_ivalid_q;
  assign mac_control_o = mac_control_q;
  assign mac_dataA_o   = mac_a_q;
  assign mac_dataB_o   = mac_b_q;
  assign res_valid_o   = res_valid_q;
  assign res_data_o    = res_data_q;

  always_comb begin
    state_d       = state_q;
    rem_d         = rem_q;
    lat_d         = lat_q;
    first_d       = first_q;
    mac_ivalid_d  = 1'b0;
    mac_control_d = 1'b0;
    mac_a_d       = mac_a_q;
    mac_b_d       = mac_b_q;
    res_valid_d   = res_valid_q;
    res_data_d    = res_data_q;
    fifo_pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          rem_d   = cmd_len_i;
          first_d = 1'b1;
          if (cmd_len_i == '0) begin
            // An empty vector has nothing to drain; its dot product is +0.0.
            state_d     = HOLD;
            res_valid_d = 1'b1;
            res_data_d  = FP_ZERO[DATA_W-1:0];
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (!fifo_empty) begin
          fifo_pop      = 1'b1;
          mac_ivalid_d  = 1'b1;
          mac_control_d = first_q;
          mac_a_d       = fifo_rdata[2*DATA_W-1:DATA_W];
          mac_b_d       = fifo_rdata[DATA_W-1:0];
          first_d       = 1'b0;
          rem_d         = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = DRAIN;
            lat_d   = LAT_W'(RES_LAT - 1);
          end
        end
      end
      DRAIN: begin
        if (lat_q == '0) begin
          res_data_d  = mac_dataout_i;
          res_valid_d = 1'b1;
          state_d     = HOLD;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      HOLD: begin
        if (res_ready_i) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!resetn_i) begin
      state_q       <= IDLE;
      rem_q         <= '0;
      lat_q         <= '0;
      first_q       <= 1'b0;
      mac_ivalid_q  <= 1'b0;
      mac_control_q <= 1'b0;
      mac_a_q       <= '0;
      mac_b_q       <= '0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      rem_q         <= rem_d;
      lat_q         <= lat_d;
      first_q       <= first_d;
      mac_ivalid_q  <= mac_ivalid_d;
      mac_control_q <= mac_control_d;
      mac_a_q       <= mac_a_d;
      mac_b_q       <= mac_b_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
    end
  end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Scoreboarded bench for mac_dot_sequencer with a behavioural FP32 MAC attached.
module tb_mac_dot_sequencer;

  localparam int DATA_W  = 32;
  localparam int DEPTH   = 16;
  localparam int RES_LAT = 12;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  logic              clock = 1'b0;
  logic              resetn = 1'b0;
  logic              ld_valid = 1'b0;
  logic              ld_ready;
  logic [DATA_W-1:0] ld_a = '0;
  logic [DATA_W-1:0] ld_b = '0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [CNT_W-1:0]  cmd_len = '0;
  logic              mac_ivalid;
  logic              mac_control;
  logic [DATA_W-1:0] mac_dataA;
  logic [DATA_W-1:0] mac_dataB;
  logic [DATA_W-1:0] mac_dataout = '0;
  logic              res_valid;
  logic              res_ready = 1'b1;
  logic [DATA_W-1:0] res_data;

  int checks = 0;
  int errors = 0;

  logic [64:0] exp_issue [$];
  logic [31:0] exp_res [$];
  logic [64:0] e_issue;
  logic [31:0] e_res;

  always #5 clock = ~clock;

  mac_dot_sequencer #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .RES_LAT (RES_LAT)
  ) dut (
    .clock_i       (clock),
    .resetn_i      (resetn),
    .ld_valid_i    (ld_valid),
    .ld_ready_o    (ld_ready),
    .ld_a_i        (ld_a),
    .ld_b_i        (ld_b),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_len_i     (cmd_len),
    .mac_ivalid_o  (mac_ivalid),
    .mac_control_o (mac_control),
    .mac_dataA_o   (mac_dataA),
    .mac_dataB_o   (mac_dataB),
    .mac_dataout_i (mac_dataout),
    .res_valid_o   (res_valid),
    .res_ready_i   (res_ready),
    .res_data_o    (res_data)
  );

  function automatic real f2r(input logic [31:0] b);
    real m;
    int  e;
    if (b[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e = e - 1; end
    while (e < 0) begin m = m / 2.0; e = e + 1; end
    return b[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic s;
    int   e;
    real  m;
    if (r == 0.0) return 32'h0;
    s = (r < 0.0);
    m = s ? -r : r;
    e = 127;
    while (m >= 2.0) begin m = m / 2.0; e = e + 1; end
    while (m < 1.0) begin m = m * 2.0; e = e - 1; end
    return {s, 8'(e), 23'($rtoi((m - 1.0) * 8388608.0))};
  endfunction

  // Behavioural MAC: accumulator output valid the cycle after each issued pair.
  always @(posedge clock) begin
    if (mac_ivalid)
      mac_dataout <= r2f((mac_control ? 0.0 : f2r(mac_dataout)) + f2r(mac_dataA) * f2r(mac_dataB));
  end

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL timeout_%s actual=expired required=event", name);
  endtask

  // Monitor: pops the scoreboard whenever the DUT issues a pair or transfers a result.
  always @(negedge clock) begin
    if (mac_control && !mac_ivalid) begin
      checks++;
      errors++;
      $display("FAIL control_without_ivalid actual=1 required=0");
    end
    if (mac_ivalid) begin
      if (exp_issue.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue actual=%h required=none", {mac_control, mac_dataA, mac_dataB});
      end else begin
        e_issue = exp_issue.pop_front();
        chk("issue", {31'd0, mac_control, mac_dataA, mac_dataB}, {31'd0, e_issue});
        $display("issue ctrl=%0b a=%h b=%h", mac_control, mac_dataA, mac_dataB);
      end
    end
    if (res_valid && res_ready) begin
      if (exp_res.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=%h required=none", res_data);
      end else begin
        e_res = exp_res.pop_front();
        chk("result", {64'd0, res_data}, {64'd0, e_res});
        $display("result data=%h", res_data);
      end
    end
  end

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic expect_it,
                      input logic ctrl);
    int  n;
    bit  ok;
    n = 0;
    ok = 1'b0;
    ld_a = a;
    ld_b = b;
    ld_valid = 1'b1;
    while (!ok && n < 200) begin
      @(negedge clock);
      ok = ld_ready;
      n++;
      if (!ok) @(posedge clock);
    end
    if (!ok) timeout("push");
    @(posedge clock);
    #1;
    ld_valid = 1'b0;
    if (expect_it) exp_issue.push_back({ctrl, a, b});
  endtask

  task automatic cmd(input int len, input logic expect_it, input logic [31:0] res);
    int n;
    bit ok;
    n = 0;
    ok = 1'b0;
    if (expect_it) exp_res.push_back(res);
    cmd_len = CNT_W'(len);
    cmd_valid = 1'b1;
    while (!ok && n < 300) begin
      @(negedge clock);
      ok = cmd_ready;
      n++;
      if (!ok) @(posedge clock);
    end
    if (!ok) timeout("cmd");
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((exp_res.size() != 0 || exp_issue.size() != 0) && n < 400) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (n >= 400) timeout(name);
    @(posedge clock);
    #1;
  endtask

  initial begin
    int n;
    // Reset and reset-state checks
    resetn = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
    @(negedge clock);
    chk("rst_ivalid", {95'd0, mac_ivalid}, 96'd0);
    chk("rst_control", {95'd0, mac_control}, 96'd0);
    chk("rst_dataA", {64'd0, mac_dataA}, 96'd0);
    chk("rst_dataB", {64'd0, mac_dataB}, 96'd0);
    chk("rst_res_valid", {95'd0, res_valid}, 96'd0);
    chk("rst_res_data", {64'd0, res_data}, 96'd0);
    chk("rst_ld_ready", {95'd0, ld_ready}, 96'd1);
    chk("rst_cmd_ready", {95'd0, cmd_ready}, 96'd1);
    @(posedge clock);
    #1;

    // 1: (1.0*2.0)+(3.0*2.0) = 8.0
    push(32'h3F800000, 32'h40000000, 1'b1, 1'b1);
    push(32'h40400000, 32'h40000000, 1'b1, 1'b0);
    cmd(2, 1'b1, 32'h41000000);
    wait_done("t1");

    // 2: 1 pair ready, 2 more trickle in with bubbles; 1+4+9 = 14.0
    push(32'h3F800000, 32'h3F800000, 1'b1, 1'b1);
    cmd(3, 1'b1, 32'h41600000);
    repeat (4) @(posedge clock);
    #1;
    push(32'h40000000, 32'h40000000, 1'b1, 1'b0);
    repeat (4) @(posedge clock);
    #1;
    push(32'h40400000, 32'h40400000, 1'b1, 1'b0);
    wait_done("t2");

    // 3: zero-length command returns +0.0 without any issue
    cmd(0, 1'b1, 32'h00000000);
    @(negedge clock);
    chk("zero_len_res_valid", {95'd0, res_valid}, 96'd1);
    wait_done("t3");

    // 4: backpressure in HOLD; 2.0*3.0 = 6.0
    res_ready = 1'b0;
    push(32'h40000000, 32'h40400000, 1'b1, 1'b1);
    cmd(1, 1'b1, 32'h40C00000);
    n = 0;
    while (!res_valid && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!res_valid) timeout("t4_res_valid");
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("hold_valid", {95'd0, res_valid}, 96'd1);
      chk("hold_data", {64'd0, res_data}, {64'd0, 32'h40C00000});
      chk("hold_cmd_ready", {95'd0, cmd_ready}, 96'd0);
    end
    @(posedge clock);
    #1;
    res_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("after_xfer_valid", {95'd0, res_valid}, 96'd0);
    chk("after_xfer_cmd_ready", {95'd0, cmd_ready}, 96'd1);
    wait_done("t4");

    // 5: fill to full, refused 17th push, drain 16 (sum 1..16 = 136.0), then refill across the wrap
    for (int k = 1; k <= 16; k++)
      push(r2f(real'(k)), 32'h3F800000, 1'b1, (k == 1));
    @(negedge clock);
    chk("full_ld_ready", {95'd0, ld_ready}, 96'd0);
    @(posedge clock);
    #1;
    ld_a = 32'h42C60000;
    ld_b = 32'h42C60000;
    ld_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("full_refuse", {95'd0, ld_ready}, 96'd0);
    end
    @(posedge clock);
    #1;
    ld_valid = 1'b0;
    cmd(16, 1'b1, 32'h43080000);
    wait_done("t5a");
    for (int k = 1; k <= 16; k++)
      push(32'h40000000, 32'h40000000, 1'b1, (k == 1));
    @(negedge clock);
    chk("refull_ld_ready", {95'd0, ld_ready}, 96'd0);
    @(posedge clock);
    #1;
    cmd(16, 1'b1, 32'h42800000);
    wait_done("t5b");

    // 6: reset after 2 of 4 issued pairs; remaining pairs must be discarded
    push(32'h3F800000, 32'h40000000, 1'b1, 1'b1);
    push(32'h40000000, 32'h40000000, 1'b1, 1'b0);
    push(32'h40400000, 32'h40400000, 1'b0, 1'b0);
    push(32'h40800000, 32'h40800000, 1'b0, 1'b0);
    cmd(4, 1'b0, 32'h0);
    n = 0;
    while (exp_issue.size() != 0 && n < 100) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (n >= 100) timeout("t6_issue");
    resetn = 1'b0;
    @(posedge clock);
    #1;
    resetn = 1'b1;
    @(negedge clock);
    chk("abort_ivalid", {95'd0, mac_ivalid}, 96'd0);
    chk("abort_cmd_ready", {95'd0, cmd_ready}, 96'd1);
    chk("abort_ld_ready", {95'd0, ld_ready}, 96'd1);
    @(posedge clock);
    #1;
    push(32'h40A00000, 32'h3F800000, 1'b1, 1'b1);
    cmd(1, 1'b1, 32'h40A00000);
    wait_done("t6");

    repeat (5) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
